gerador_serial: RTL and testbench

Serial bit-stream transmitter that drives the single-bit input of the team's ones-counting serial analyser.
- Accepts a parallel word and a bit count, then shifts the bits out LSB-first, one per clock, with a valid qualifier.
- Keeps its own mod-4 count of transmitted ones, so a bench can compare its `match` against the analyser's `y`.
- Sits between stimulus or control logic and the analyser's serial input.

---
 rtl/gerador_serial.sv | 56 +++++
 tb/tb_gerador_serial.sv | 132 +++++++++++++
 2 files changed

// File: rtl/gerador_serial.sv
// gerador_serial: LSB-first serial transmitter with valid qualifier, pause and mod-4 count of ones sent
module gerador_serial #(
  parameter int WIDTH = 8,
  localparam int LW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dado,
  input  logic [LW-1:0]    len,
  input  logic             pause,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       ones_mod4,
  output logic             match
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [LW-1:0] cnt, n, len_c;
  assign len_c = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      n <= '0;
      ones_mod4 <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sr <= dado;
          n <= len_c;
          cnt <= '0;
          ones_mod4 <= '0;
          state <= (len_c == '0) ? DONE : SHIFT;
        end
        SHIFT: if (!pause) begin
          sr <= sr >> 1;
          cnt <= cnt + 1'b1;
          ones_mod4 <= ones_mod4 + {1'b0, sr[0]};
          if (cnt + 1'b1 == n) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign ser_out = (state == SHIFT) && sr[0];
  assign ser_valid = (state == SHIFT) && !pause;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign match = &ones_mod4;
endmodule

// File: tb/tb_gerador_serial.sv
// tb_gerador_serial: scoreboard bench for gerador_serial bit stream, timing, pause, clamp and abort
module tb_gerador_serial;
  logic clk = 0, rst = 1, start = 0, pause = 0;
  logic [7:0] dado = '0;
  logic [3:0] len = '0;
  logic ser_out, ser_valid, busy, done, match;
  logic [1:0] ones_mod4;
  int errors = 0, checks = 0, mc;
  logic sb[$];
  gerador_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dado(dado), .len(len), .pause(pause),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done),
    .ones_mod4(ones_mod4), .match(match)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (!rst && ser_valid === 1'b1) begin
      if (sb.size() == 0) chk("extra_bit", 1, 0);
      else chk("bit", ser_out, sb.pop_front());
    end
  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, ser_valid, 0);
    chk({tag, "_out"}, ser_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ones"}, ones_mod4, 0);
    chk({tag, "_match"}, match, 0);
  endtask
  task automatic send(input logic [7:0] d, input int l);
    int n;
    n = l > 8 ? 8 : l;
    for (int i = 0; i < n; i++) sb.push_back(d[i]);
    dado = d;
    len = 4'(l);
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  // Walks the transfer cycle by cycle from k+1 against a behavioural model of the transmitter.
  task automatic run(input logic [7:0] d, input int l, input int plo, input int phi, input int sj, output int mcnt);
    int n, s, ones;
    logic p, ph;
    n = l > 8 ? 8 : l;
    s = 0; ones = 0; mcnt = 0; ph = 0;
    for (int j = 1; j <= 40; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      p = (j >= plo && j <= phi);
      pause = p;
      start = (j == sj);
      if (j == sj) begin dado = 8'hFF; len = 4'd3; end
      @(negedge clk);
      mcnt += int'(match);
      if (s < n) begin
        chk("valid", ser_valid, !p);
        chk("out", ser_out, d[s]);
        chk("busy", busy, 1);
        chk("done", done, 0);
        chk("ones", ones_mod4, ones);
        chk("match", match, ones == 3);
        if (!p) begin ones = (ones + int'(d[s])) % 4; s++; end
      end else if (!ph) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", ser_valid, 0);
        chk("done_out", ser_out, 0);
        chk("done_ones", ones_mod4, ones);
        ph = 1;
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", ser_valid, 0);
        chk("idle_ones", ones_mod4, ones);
        chk("idle_match", match, ones == 3);
        break;
      end
    end
    pause = 0;
    start = 0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    start = 1; dado = 8'h07; len = 4'd8;
    repeat (2) begin
      @(posedge clk);
      #1 all_zero("rst");
    end
    rst = 0;
    send(8'h07, 8);
    run(8'h07, 8, 0, 0, 0, mc);
    send(8'hFF, 5);
    run(8'hFF, 5, 0, 0, 0, mc);
    chk("ff_match_cycles", mc, 1);
    send(8'hA5, 8);
    run(8'hA5, 8, 3, 5, 0, mc);
    send(8'h5A, 0);
    run(8'h5A, 0, 0, 0, 0, mc);
    send(8'hC3, 15);
    run(8'hC3, 15, 0, 0, 0, mc);
    send(8'h96, 8);
    run(8'h96, 8, 0, 0, 4, mc);
    send(8'hB7, 8);
    for (int j = 1; j <= 3; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      if (j == 3) rst = 1;
      @(negedge clk);
      chk("abort_valid", ser_valid, 1);
    end
    @(posedge clk);
    #1 rst = 0;
    sb.delete();
    all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end
    @(posedge clk);
    #1;
    send(8'h3C, 6);
    run(8'h3C, 6, 0, 0, 0, mc);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
